// File: rtl/gate_delay_gen_mc_if.sv
// Bus interface for gate_delay_gen_mc.
// Carries the trigger, latched timing config, miss-counter clear and all gate/status outputs.
// master: driver of trigger/config (register block or testbench).
// slave : the gate/delay generator itself.
// Optional burst signals (i_burst_cnt, i_period, o_burst_idx) exist only when GATE_BURST_EN is defined.
interface gate_delay_gen_mc_if #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned MISS_W = 16
);
    logic                   i_trigger;
    logic [NCH-1:0]         i_ch_en;
    logic [NCH*CNT_W-1:0]   i_delay;
    logic [NCH*CNT_W-1:0]   i_width;
    logic                   i_clr_miss;
    logic [NCH-1:0]         o_pulse;
    logic                   o_busy;
    logic                   o_done;
    logic [MISS_W-1:0]      o_missed;
`ifdef GATE_BURST_EN
    logic [15:0]            i_burst_cnt;
    logic [CNT_W-1:0]       i_period;
    logic [15:0]            o_burst_idx;

    modport master (
        output i_trigger, i_ch_en, i_delay, i_width, i_clr_miss, i_burst_cnt, i_period,
        input  o_pulse, o_busy, o_done, o_missed, o_burst_idx
    );
    modport slave (
        input  i_trigger, i_ch_en, i_delay, i_width, i_clr_miss, i_burst_cnt, i_period,
        output o_pulse, o_busy, o_done, o_missed, o_burst_idx
    );
`else
    modport master (
        output i_trigger, i_ch_en, i_delay, i_width, i_clr_miss,
        input  o_pulse, o_busy, o_done, o_missed
    );
    modport slave (
        input  i_trigger, i_ch_en, i_delay, i_width, i_clr_miss,
        output o_pulse, o_busy, o_done, o_missed
    );
`endif
endinterface

// File: rtl/gate_delay_gen_mc.sv
// Multi-channel gate/delay generator.
// An asynchronous trigger edge (2-FF synchronised, edge detected) starts a shared timebase t;
// channel k drives a gate while delay_k <= t < delay_k+width_k. Config is latched at trigger.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : i_trigger, i_ch_en, i_delay, i_width, i_clr_miss in;
//                    o_pulse, o_busy, o_done, o_missed out (all registered)
// Optional feature macro GATE_BURST_EN: adds i_burst_cnt, i_period and o_burst_idx for
// repeating the sequence with period max(i_period, T_end).
module gate_delay_gen_mc #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned MISS_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    gate_delay_gen_mc_if.slave bus
);
    localparam int unsigned TW = CNT_W + 1;   // timebase never wraps within a sequence
    localparam int unsigned DW = NCH * CNT_W;
    localparam int unsigned BW = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync2_q, edge_q;
    logic              trig_evt_c;
    logic [TW-1:0]     t_q, t_d;
    logic [TW-1:0]     rep_len_q, rep_len_d;
    logic [TW-1:0]     tend_c;
    logic [NCH-1:0]    en_q, en_d;
    logic [DW-1:0]     delay_q, delay_d;
    logic [DW-1:0]     width_q, width_d;
    logic [NCH-1:0]    pulse_q, pulse_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [MISS_W-1:0] missed_q, missed_d;
    logic              rep_end_c, last_rep_c;
`ifdef GATE_BURST_EN
    logic [BW-1:0]     reps_q, reps_d;
    logic [BW-1:0]     idx_q, idx_d;
    logic [TW-1:0]     period_c;
`endif

    // Sequence length: latest gate end over enabled, non-zero-width channels; 1 if none.
    function automatic logic [TW-1:0] seq_end(input logic [NCH-1:0] en,
                                               input logic [DW-1:0]  dly,
                                               input logic [DW-1:0]  wid);
        logic [TW-1:0] mx;
        logic [TW-1:0] e;
        mx = TW'(1);
        for (int k = 0; k < NCH; k++) begin
            e = TW'(dly[k*CNT_W +: CNT_W]) + TW'(wid[k*CNT_W +: CNT_W]);
            if (en[k] && (wid[k*CNT_W +: CNT_W] != '0) && (e > mx)) begin
                mx = e;
            end
        end
        return mx;
    endfunction

    // Gate levels for timebase value t; zero width yields an empty window.
    function automatic logic [NCH-1:0] gate_at(input logic [NCH-1:0] en,
                                               input logic [DW-1:0]  dly,
                                               input logic [DW-1:0]  wid,
                                               input logic [TW-1:0]  t);
        logic [NCH-1:0] g;
        logic [TW-1:0]  d;
        logic [TW-1:0]  e;
        g = '0;
        for (int k = 0; k < NCH; k++) begin
            d    = TW'(dly[k*CNT_W +: CNT_W]);
            e    = d + TW'(wid[k*CNT_W +: CNT_W]);
            g[k] = en[k] && (t >= d) && (t < e);
        end
        return g;
    endfunction

    // Trigger synchroniser plus previous-value register for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= bus.i_trigger;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign trig_evt_c = sync2_q & ~edge_q;

    // State, timebase, latched config and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            t_q       <= '0;
            rep_len_q <= '0;
            en_q      <= '0;
            delay_q   <= '0;
            width_q   <= '0;
            pulse_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            missed_q  <= '0;
`ifdef GATE_BURST_EN
            reps_q    <= '0;
            idx_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            rep_len_q <= rep_len_d;
            en_q      <= en_d;
            delay_q   <= delay_d;
            width_q   <= width_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            missed_q  <= missed_d;
`ifdef GATE_BURST_EN
            reps_q    <= reps_d;
            idx_q     <= idx_d;
`endif
        end
    end

    // Next state; outputs are computed from next-cycle t so they line up with t exactly.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        rep_len_d = rep_len_q;
        en_d      = en_q;
        delay_d   = delay_q;
        width_d   = width_q;
        done_d    = 1'b0;
        tend_c    = seq_end(bus.i_ch_en, bus.i_delay, bus.i_width);
        rep_end_c = (t_q == (rep_len_q - TW'(1)));
`ifdef GATE_BURST_EN
        reps_d     = reps_q;
        idx_d      = idx_q;
        period_c   = TW'(bus.i_period);
        last_rep_c = (idx_q == (reps_q - BW'(1)));
`else
        last_rep_c = 1'b1;
`endif

        case (state_q)
            ST_IDLE: begin
                if (trig_evt_c) begin
                    state_d = ST_RUN;
                    t_d     = '0;
                    en_d    = bus.i_ch_en;
                    delay_d = bus.i_delay;
                    width_d = bus.i_width;
`ifdef GATE_BURST_EN
                    // Repetition period is clamped so a repetition never truncates a gate.
                    rep_len_d = (period_c > tend_c) ? period_c : tend_c;
                    reps_d    = (bus.i_burst_cnt == '0) ? BW'(1) : bus.i_burst_cnt;
                    idx_d     = '0;
`else
                    rep_len_d = tend_c;
`endif
                end
            end
            ST_RUN: begin
                if (rep_end_c) begin
                    t_d = '0;
                    if (last_rep_c) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`ifdef GATE_BURST_EN
                        idx_d   = '0;
`endif
                    end
`ifdef GATE_BURST_EN
                    else begin
                        idx_d = idx_q + BW'(1);
                    end
`endif
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d == ST_RUN);
        pulse_d = busy_d ? gate_at(en_d, delay_d, width_d, t_d) : '0;

        // Clear wins over a coincident rejected trigger; count saturates.
        if (bus.i_clr_miss) begin
            missed_d = '0;
        end else if (trig_evt_c && busy_q && (missed_q != {MISS_W{1'b1}})) begin
            missed_d = missed_q + MISS_W'(1);
        end else begin
            missed_d = missed_q;
        end
    end

    assign bus.o_pulse  = pulse_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
    assign bus.o_missed = missed_q;
`ifdef GATE_BURST_EN
    assign bus.o_burst_idx = idx_q;
`endif

endmodule

// File: tb/tb_gate_delay_gen_mc.sv
// Self-checking bench for gate_delay_gen_mc: directed and random trigger windows compared
// against a per-window arithmetic reference of the gate/busy/done/miss rules.
module tb_gate_delay_gen_mc;
    localparam int unsigned NCH    = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned MISS_W = 16;
    localparam int          MAXC   = 256;

    typedef struct {
        logic [NCH-1:0]            en;
        logic [NCH-1:0][CNT_W-1:0] dly;
        logic [NCH-1:0][CNT_W-1:0] wid;
        int unsigned               bcnt;
        int unsigned               period;
    } cfg_t;

    logic clk;
    logic rst_n;

    gate_delay_gen_mc_if #(.NCH(NCH), .CNT_W(CNT_W), .MISS_W(MISS_W)) bus ();

    gate_delay_gen_mc #(.NCH(NCH), .CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit             trig_pat [MAXC];
    bit             clr_pat  [MAXC];
    cfg_t           cfg_a, cfg_b;
    int             chg_at;
    int             abort_at;
    int             miss_model;
    bit             exp_busy  [MAXC];
    bit             exp_done  [MAXC];
    logic [NCH-1:0] exp_pulse [MAXC];
    int             exp_miss  [MAXC];
    int             exp_idx   [MAXC];

    task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, expv);
        end
    endtask

    function automatic cfg_t cfg4(input logic [NCH-1:0] en,
                                  input int d0, input int d1, input int d2, input int d3,
                                  input int w0, input int w1, input int w2, input int w3,
                                  input int bcnt, input int period);
        cfg_t c;
        c.en     = en;
        c.dly[0] = CNT_W'(d0); c.dly[1] = CNT_W'(d1); c.dly[2] = CNT_W'(d2); c.dly[3] = CNT_W'(d3);
        c.wid[0] = CNT_W'(w0); c.wid[1] = CNT_W'(w1); c.wid[2] = CNT_W'(w2); c.wid[3] = CNT_W'(w3);
        c.bcnt   = bcnt;
        c.period = period;
        return c;
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.en = NCH'($urandom);
        for (int k = 0; k < NCH; k++) begin
            c.dly[k] = CNT_W'($urandom_range(12, 0));
            c.wid[k] = CNT_W'($urandom_range(6, 0));
        end
        c.bcnt   = $urandom_range(2, 0);
        c.period = $urandom_range(24, 0);
        return c;
    endfunction

    task automatic apply_cfg(input cfg_t c);
        bus.i_ch_en = c.en;
        bus.i_delay = c.dly;
        bus.i_width = c.wid;
`ifdef GATE_BURST_EN
        bus.i_burst_cnt = 16'(c.bcnt);
        bus.i_period    = CNT_W'(c.period);
`endif
    endtask

    task automatic clear_pats();
        for (int c = 0; c < MAXC; c++) begin
            trig_pat[c] = 1'b0;
            clr_pat[c]  = 1'b0;
        end
        chg_at   = MAXC;
        abort_at = MAXC;
    endtask

    // Reference: a sequence starts the cycle after an accepted edge event (edge + 2 cycles),
    // lasts reps * L cycles, done follows; events while busy are counted as missed.
    task automatic build_model(input int n);
        bit     act, evt, prev, b;
        int     s, m;
        longint L, reps, tt, t, d, w, tend;
        cfg_t   cur, inc;
        act = 1'b0; s = 0; L = 1; reps = 1; m = miss_model; cur = cfg_a;
        for (int c = 0; c < n; c++) begin
            if (c < chg_at) inc = cfg_a; else inc = cfg_b;
            evt = 1'b0;
            if (c >= 2) begin
                prev = (c >= 3) ? trig_pat[c-3] : 1'b0;
                evt  = trig_pat[c-2] && !prev;
            end
            exp_pulse[c] = '0;
            exp_idx[c]   = 0;
            if (c >= abort_at) begin
                act = 1'b0; m = 0;
                exp_busy[c] = 1'b0; exp_done[c] = 1'b0; exp_miss[c] = 0;
            end else begin
                tt = longint'(c - s);
                b  = act && (tt < reps * L);
                exp_busy[c] = b;
                exp_done[c] = act && (tt == reps * L);
                if (b) begin
                    t          = tt % L;
                    exp_idx[c] = int'(tt / L);
                    for (int k = 0; k < NCH; k++) begin
                        d = longint'(cur.dly[k]);
                        w = longint'(cur.wid[k]);
                        exp_pulse[c][k] = cur.en[k] && (d <= t) && (t < d + w);
                    end
                end
                exp_miss[c] = m;
                if (clr_pat[c]) m = 0;
                else if (evt && b && (m < (1 << MISS_W) - 1)) m++;
                if (evt && !b) begin
                    act = 1'b1; s = c + 1; cur = inc; tend = 1;
                    for (int k = 0; k < NCH; k++) begin
                        d = longint'(cur.dly[k]);
                        w = longint'(cur.wid[k]);
                        if (cur.en[k] && (w > 0) && (d + w > tend)) tend = d + w;
                    end
`ifdef GATE_BURST_EN
                    L    = (longint'(cur.period) > tend) ? longint'(cur.period) : tend;
                    reps = (cur.bcnt == 0) ? 1 : longint'(cur.bcnt);
`else
                    L    = tend;
                    reps = 1;
`endif
                end
            end
        end
        miss_model = m;
    endtask

    task automatic run_window(input string name, input int n);
        build_model(n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            bus.i_trigger  = trig_pat[c];
            bus.i_clr_miss = clr_pat[c];
            if (c < chg_at) apply_cfg(cfg_a); else apply_cfg(cfg_b);
            if (c == abort_at)     rst_n = 1'b0;
            if (c == abort_at + 3) rst_n = 1'b1;
            @(negedge clk);
            chk($sformatf("%s.busy", name),   c, 64'(bus.o_busy),   64'(exp_busy[c]));
            chk($sformatf("%s.pulse", name),  c, 64'(bus.o_pulse),  64'(exp_pulse[c]));
            chk($sformatf("%s.done", name),   c, 64'(bus.o_done),   64'(exp_done[c]));
            chk($sformatf("%s.missed", name), c, 64'(bus.o_missed), 64'(exp_miss[c]));
`ifdef GATE_BURST_EN
            chk($sformatf("%s.idx", name),    c, 64'(bus.o_burst_idx), 64'(exp_idx[c]));
`endif
        end
    endtask

    initial begin
        int a;
        rst_n          = 1'b0;
        bus.i_trigger  = 1'b0;
        bus.i_clr_miss = 1'b0;
        cfg_a          = cfg4(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cfg_b          = cfg_a;
        apply_cfg(cfg_a);
        miss_model     = 0;
        clear_pats();

        // Reset state, then 100 idle cycles with everything low.
        #2;
        chk("reset.busy",   0, 64'(bus.o_busy),   64'd0);
        chk("reset.missed", 0, 64'(bus.o_missed), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk("idle.busy",   c, 64'(bus.o_busy),   64'd0);
            chk("idle.pulse",  c, 64'(bus.o_pulse),  64'd0);
            chk("idle.done",   c, 64'(bus.o_done),   64'd0);
            chk("idle.missed", c, 64'(bus.o_missed), 64'd0);
        end

        // Reference vector with two extra edges landing inside busy.
        clear_pats();
        cfg_a = cfg4(4'b1111, 0, 5, 10, 3, 2, 3, 0, 1, 1, 0);
        trig_pat[0] = 1; trig_pat[1] = 1; trig_pat[4] = 1; trig_pat[5] = 1;
        trig_pat[8] = 1; trig_pat[9] = 1;
        run_window("vec", 20);
        chk("vec.missed_two", 0, 64'(bus.o_missed), 64'd2);

        // Clear together with a third in-busy edge; config changes mid-run.
        clear_pats();
        cfg_b = cfg4(4'b1111, 1, 2, 3, 4, 4, 4, 4, 4, 1, 0);
        chg_at = 5;
        trig_pat[0] = 1; trig_pat[1] = 1; trig_pat[4] = 1; trig_pat[5] = 1;
        clr_pat[6] = 1;
        run_window("clr", 20);
        chk("clr.missed_zero", 0, 64'(bus.o_missed), 64'd0);

        // Next trigger picks up the new config.
        clear_pats();
        cfg_a = cfg_b;
        trig_pat[0] = 1; trig_pat[1] = 1;
        run_window("newcfg", 20);

        // Trigger event coincident with done is accepted.
        clear_pats();
        trig_pat[0] = 1; trig_pat[1] = 1; trig_pat[9] = 1; trig_pat[10] = 1;
        run_window("b2b", 26);

        // No qualifying channel: one busy cycle.
        clear_pats();
        cfg_a = cfg4(4'b0000, 3, 3, 3, 3, 5, 5, 5, 5, 1, 0);
        trig_pat[0] = 1; trig_pat[1] = 1;
        run_window("noch", 10);
        clear_pats();
        cfg_a = cfg4(4'b1111, 3, 3, 3, 3, 0, 0, 0, 0, 1, 0);
        trig_pat[0] = 1; trig_pat[1] = 1;
        run_window("zerow", 10);

        // Reset mid-sequence at t=4 of a delay=2 width=10 run, then a normal run.
        clear_pats();
        cfg_a = cfg4(4'b0001, 2, 0, 0, 0, 10, 0, 0, 0, 1, 0);
        trig_pat[0] = 1; trig_pat[1] = 1;
        abort_at = 7;
        run_window("abort", 20);
        clear_pats();
        trig_pat[0] = 1; trig_pat[1] = 1;
        run_window("after_rst", 20);

        // Random configs, extra edges, clears and mid-run config changes.
        for (int r = 0; r < 12; r++) begin
            clear_pats();
            cfg_a = rand_cfg();
            cfg_b = rand_cfg();
            trig_pat[0] = 1; trig_pat[1] = 1;
            if ($urandom_range(1, 0) == 1) begin
                a = 4 + int'($urandom_range(19, 0));
                trig_pat[a] = 1; trig_pat[a+1] = 1;
            end
            if ($urandom_range(3, 0) == 0) clr_pat[$urandom_range(40, 0)] = 1;
            if ($urandom_range(1, 0) == 1) chg_at = int'($urandom_range(29, 0));
            run_window($sformatf("rnd%0d", r), 90);
        end

`ifdef GATE_BURST_EN
        // Burst of 3 with period 20, then with a period clamped up to T_end=3.
        clear_pats();
        cfg_a = cfg4(4'b0001, 1, 0, 0, 0, 2, 0, 0, 0, 3, 20);
        trig_pat[0] = 1; trig_pat[1] = 1;
        run_window("burst20", 72);
        clear_pats();
        cfg_a = cfg4(4'b0001, 1, 0, 0, 0, 2, 0, 0, 0, 3, 2);
        trig_pat[0] = 1; trig_pat[1] = 1;
        run_window("burst2", 20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gate_delay_gen_mc.md
Name: gate_delay_gen_mc

Overview:
- Multi-channel successor to the single-channel gate/delay generator.
- One asynchronous trigger starts a shared timebase. Each of NCH channels produces a gate with its own delay and width.
- Sits between the experiment trigger input and the downstream gate/strobe outputs. Timing config comes from the register block.
- Adds per-channel enables, config latching at trigger, a missed-trigger counter, a done strobe and optional burst repetition.

Parameters:
- NCH, 4, number of gate channels (1..16).
- CNT_W, 32, width of delay, width and timebase fields.
- MISS_W, 16, width of the missed-trigger counter.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_trigger  in  1  asynchronous trigger input; rising edge starts a sequence.
- i_ch_en  in  NCH  per-channel enable; latched at trigger.
- i_delay  in  NCH*CNT_W  per-channel delay; channel k is bits [k*CNT_W +: CNT_W].
- i_width  in  NCH*CNT_W  per-channel gate width, same packing.
- i_clr_miss  in  1  synchronous clear of o_missed.
- o_pulse  out  NCH  registered gate outputs.
- o_busy  out  1  high while a sequence runs.
- o_done  out  1  one-cycle strobe when a sequence (or burst) ends.
- o_missed  out  MISS_W  count of trigger edges rejected while busy; saturating.

Behaviour:
- Reset: asynchronous, active-low. Clears sync flops, edge register, timebase, latched config, state (IDLE), o_pulse=0, o_busy=0, o_done=0, o_missed=0.
- Reset asserted mid-sequence aborts immediately; all outputs go low with no o_done.
- Trigger path: 2-FF synchroniser, then a registered rising-edge detect producing trig_evt, which is high for 1 cycle.
- Fixed latency: i_trigger rising edge to first busy cycle is 3 i_clk cycles.
- State machine, IDLE -> RUN:
  - Entered on trig_evt.
  - Latches i_ch_en, i_delay and i_width for all channels.
  - Timebase t=0 in the first RUN cycle; t increments by 1 per cycle.
  - Config changes during RUN have no effect.
- Outputs during RUN:
  - o_pulse[k] is high in cycle t iff ch_en[k] and delay_k <= t < delay_k+width_k.
  - width_k=0 gives no pulse.
  - The comparison is registered so o_pulse aligns to t exactly (pre-compute from t-1).
- End of sequence:
  - T_end = max(delay_k+width_k) over enabled channels with width_k>0, computed at CNT_W+1 bits (no wrap).
  - If no channel qualifies, T_end=1.
  - o_busy is high for t=0..T_end-1.
- RUN -> IDLE: after the cycle t=T_end-1. o_done=1 in the first IDLE cycle only.
- Missed triggers:
  - trig_evt while o_busy=1 is ignored and increments o_missed; it saturates at all-ones.
  - trig_evt coincident with the o_done cycle is accepted: a new RUN starts the next cycle.
- Clearing o_missed:
  - i_clr_miss clears o_missed.
  - i_clr_miss has priority over a simultaneous increment; the result is 0.
- Timebase: CNT_W+1 bits wide; never wraps within a sequence.

Optional Feature:
- Macro: GATE_BURST_EN.
- Defined: adds ports i_burst_cnt (in, 16) and i_period (in, CNT_W), both latched at trigger.
  - The sequence repeats i_burst_cnt times; 0 is treated as 1.
  - Each repetition restarts t=0 after max(i_period, T_end) cycles. A period shorter than T_end is clamped.
  - o_busy stays high continuously across repetitions.
  - o_done pulses once, after the final repetition.
  - Output port o_burst_idx (out, 16) gives the current repetition index, 0-based; it is 0 in IDLE.
- Not defined: ports absent; single-shot behaviour as above.

Test Plan:
- Reset release, no trigger -> all outputs 0 for 100 cycles; o_missed=0.
- NCH=4, en=4'b1111, delays {0,5,10,3}, widths {2,3,0,1}; raise i_trigger:
  - o_busy rises 3 cycles later and lasts 8 cycles (T_end=8).
  - ch0 high at t=0..1, ch1 at t=5..7, ch2 never, ch3 at t=3.
  - o_done pulses once at t=8.
- Two extra trigger edges during busy -> o_missed=2, sequence timing unchanged. Then assert i_clr_miss together with a third in-busy edge -> o_missed=0.
- Change i_delay/i_width mid-sequence -> current pulses unchanged; the next trigger uses the new values.
- Deassert i_rst_n at t=4 of a delay=2, width=10 run -> o_pulse, o_busy drop immediately with no o_done. After release, a new trigger runs normally.
- With GATE_BURST_EN: burst_cnt=3, period=20, ch0 delay=1 width=2:
  - ch0 high at t=1..2 of each repetition (absolute offsets 1, 21, 41).
  - o_busy lasts 60 cycles, o_burst_idx steps 0→1→2, one o_done.
  - Repeat with period=2 -> clamped to T_end=3.
